// File: rtl/washer_view_scan.sv
// Washer display/LED front end: registered status LEDs plus a time-multiplexed digit scan
// with blink timing for error, pause and finish states.
module washer_view_scan #(
  parameter int NUM_DIGITS = 3,
  parameter int NUM_LEDS   = 8,
  parameter int BLINK_DIV  = 25000,
  parameter int SCAN_DIV   = 500
) (
  input  logic                    cp,
  input  logic                    rst_n,
  input  logic [2:0]              state,
  input  logic [NUM_LEDS+1:0]     data,
  input  logic [6*NUM_DIGITS-1:0] digits_in,
  output logic [NUM_LEDS-1:0]     led,
  output logic                    power_led,
  output logic                    set_led,
  output logic [NUM_DIGITS-1:0]   scan_sel,
  output logic [5:0]              scan_code
);

  localparam int MID = NUM_DIGITS / 2;
  localparam int BW  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int SW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [5:0] CODE_EMPTY = 6'd55;
  localparam logic [5:0] CODE_FULL  = 6'd56;
  localparam logic [5:0] CODE_PAUSE = 6'd57;

  typedef enum logic [2:0] {
    SHUTDOWN = 3'd0,
    BEGIN_ST = 3'd1,
    SET_ST   = 3'd2,
    RUN      = 3'd3,
    ERROR    = 3'd4,
    PAUSE    = 3'd5,
    FINISH   = 3'd6,
    ILLEGAL  = 3'd7
  } stateT;

  stateT          curState;
  logic [2:0]     prevState;
  logic [BW-1:0]  blinkCnt;
  logic           blinkOn;
  logic [SW-1:0]  scanCnt;
  logic [IW-1:0]  scanIdx;

  logic           blinkWrap;
  logic           restart;
  logic           blinkNext;
  logic           scanWrap;
  logic           isMid;
  logic [5:0]     curDigit;
  logic [5:0]     effCode;
  logic [NUM_LEDS-1:0] ledNext;

  assign curState  = stateT'(state);
  assign blinkWrap = (blinkCnt == BW'(BLINK_DIV - 1));
  assign scanWrap  = (scanCnt == SW'(SCAN_DIV - 1));
  assign restart   = (state != prevState) &&
                     (curState == ERROR || curState == PAUSE || curState == FINISH);
  // Outputs use the post-edge blink phase so a restart is visible on the same edge.
  assign blinkNext = restart ? 1'b1 : (blinkWrap ? ~blinkOn : blinkOn);
  assign isMid     = (scanIdx == IW'(MID));

  always_comb begin
    curDigit = digits_in[5:0];
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (scanIdx == IW'(k)) curDigit = digits_in[6*k +: 6];
    end
  end

  always_comb begin
    effCode = CODE_EMPTY;
    ledNext = '0;
    case (curState)
      BEGIN_ST: begin
        effCode = CODE_FULL;
        ledNext = '1;
      end
      SET_ST, RUN: begin
        effCode = curDigit;
        ledNext = data[NUM_LEDS-1:0];
      end
      ERROR: begin
        effCode = blinkNext ? curDigit : CODE_EMPTY;
        ledNext = data[NUM_LEDS-1:0];
      end
      PAUSE: begin
        effCode = (isMid && blinkNext) ? CODE_PAUSE : curDigit;
        ledNext = data[NUM_LEDS-1:0];
      end
      FINISH: begin
        effCode = blinkNext ? CODE_FULL : CODE_EMPTY;
        ledNext = blinkNext ? '1 : '0;
      end
      default: begin
        effCode = CODE_EMPTY;
        ledNext = '0;
      end
    endcase
  end

  always_ff @(posedge cp or negedge rst_n) begin
    if (!rst_n) begin
      led       <= '0;
      power_led <= 1'b0;
      set_led   <= 1'b0;
      scan_sel  <= NUM_DIGITS'(1);
      scan_code <= CODE_EMPTY;
      blinkCnt  <= '0;
      blinkOn   <= 1'b1;
      scanCnt   <= '0;
      scanIdx   <= '0;
      prevState <= 3'd0;
    end else begin
      prevState <= state;
      blinkOn   <= blinkNext;
      if (restart || blinkWrap) blinkCnt <= '0;
      else                      blinkCnt <= blinkCnt + BW'(1);

      if (scanWrap) begin
        scanCnt <= '0;
        scanIdx <= (scanIdx == IW'(NUM_DIGITS - 1)) ? '0 : scanIdx + IW'(1);
      end else begin
        scanCnt <= scanCnt + SW'(1);
      end

      led       <= ledNext;
      power_led <= data[NUM_LEDS];
      set_led   <= data[NUM_LEDS+1];
      scan_sel  <= NUM_DIGITS'(1) << scanIdx;
      scan_code <= effCode;
    end
  end

endmodule

// File: tb/tb_washer_view_scan.sv
// Directed bench for washer_view_scan with NUM_DIGITS=3, NUM_LEDS=8, BLINK_DIV=4, SCAN_DIV=2.
module tb_washer_view_scan;

  logic        cp = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  state = 3'd3;
  logic [9:0]  data = 10'h3FF;
  logic [17:0] digitsIn;
  logic [7:0]  led;
  logic        powerLed, setLed;
  logic [2:0]  scanSel;
  logic [5:0]  scanCode;

  logic [5:0]  dig [3];
  int          nChecks = 0;
  int          nPass = 0;
  int          cyc = 0;

  washer_view_scan #(
    .NUM_DIGITS(3), .NUM_LEDS(8), .BLINK_DIV(4), .SCAN_DIV(2)
  ) dut (
    .cp(cp), .rst_n(rst_n), .state(state), .data(data), .digits_in(digitsIn),
    .led(led), .power_led(powerLed), .set_led(setLed),
    .scan_sel(scanSel), .scan_code(scanCode)
  );

  always #5 cp = ~cp;
  assign digitsIn = {dig[2], dig[1], dig[0]};

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge cp);
    #1;
    cyc++;
  endtask

  // Digit index shown at the edge numbered c after reset release (first edge is 1).
  function automatic int expIdx(input int c);
    return ((c - 1) / 2) % 3;
  endfunction

  function automatic logic [2:0] oneHot(input int i);
    logic [2:0] one;
    one = 3'b001;
    return one << i;
  endfunction

  // Blink phase at edge e for a restart on edge n: on for 4 edges, off for 4.
  function automatic bit blinkPhase(input int e, input int n);
    return (((e - n) / 4) % 2) == 0;
  endfunction

  task automatic checkPause(input int n, input int edges, input string tag);
    int idx;
    for (int k = 0; k < edges; k++) begin
      tick();
      idx = expIdx(cyc);
      checkVal({tag, "_sel"}, 32'(scanSel), 32'(oneHot(idx)));
      if (idx == 1) checkVal({tag, "_mid"}, 32'(scanCode), blinkPhase(cyc, n) ? 32'd57 : 32'(dig[1]));
      else          checkVal({tag, "_side"}, 32'(scanCode), 32'(dig[idx]));
      checkVal({tag, "_led"}, 32'(led), 32'(data[7:0]));
    end
  endtask

  initial begin
    int idx;
    int n;
    dig[0] = 6'd1; dig[1] = 6'd2; dig[2] = 6'd3;

    // Reset held with run state and all data ones
    repeat (3) tick();
    checkVal("rst_led", 32'(led), 32'h0);
    checkVal("rst_sel", 32'(scanSel), 32'b001);
    checkVal("rst_code", 32'(scanCode), 32'd55);
    checkVal("rst_pwr", 32'(powerLed), 32'd0);
    checkVal("rst_set", 32'(setLed), 32'd0);

    // Run: scan sequence and LED pass-through
    data  = 10'h2A5;
    rst_n = 1'b1;
    cyc   = 0;
    for (int k = 0; k < 7; k++) begin
      tick();
      idx = expIdx(cyc);
      checkVal("run_sel", 32'(scanSel), 32'(oneHot(idx)));
      checkVal("run_code", 32'(scanCode), 32'(dig[idx]));
    end
    checkVal("run_led", 32'(led), 32'hA5);
    checkVal("run_pwr", 32'(powerLed), 32'd0);
    checkVal("run_set", 32'(setLed), 32'd1);

    // Lamp test
    state = 3'd1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checkVal("begin_sel", 32'(scanSel), 32'(oneHot(expIdx(cyc))));
      checkVal("begin_code", 32'(scanCode), 32'd56);
      checkVal("begin_led", 32'(led), 32'hFF);
    end

    // Run -> pause restarts blink with the middle digit showing pause
    state = 3'd3;
    repeat (3) tick();
    state = 3'd5;
    checkPause(cyc + 1, 12, "pause");

    // Run -> error, then error -> pause mid-period
    state = 3'd3;
    data  = 10'h05A;
    repeat (2) tick();
    state = 3'd4;
    n = cyc + 1;
    for (int k = 0; k < 5; k++) begin
      tick();
      idx = expIdx(cyc);
      checkVal("err_code", 32'(scanCode), blinkPhase(cyc, n) ? 32'(dig[idx]) : 32'd55);
      checkVal("err_led", 32'(led), 32'h5A);
    end
    state = 3'd5;
    checkPause(cyc + 1, 8, "err2pause");

    // Finish: LEDs and codes blink together, power LED unaffected
    state = 3'd6;
    data  = 10'h13C;
    n = cyc + 1;
    for (int k = 0; k < 9; k++) begin
      tick();
      checkVal("fin_led", 32'(led), blinkPhase(cyc, n) ? 32'hFF : 32'h00);
      checkVal("fin_code", 32'(scanCode), blinkPhase(cyc, n) ? 32'd56 : 32'd55);
      checkVal("fin_pwr", 32'(powerLed), 32'd1);
      checkVal("fin_set", 32'(setLed), 32'd0);
    end

    // Illegal behaves as shutdown
    state = 3'd7;
    data  = 10'h3FF;
    repeat (2) tick();
    checkVal("ill_code", 32'(scanCode), 32'd55);
    checkVal("ill_led", 32'(led), 32'h00);
    checkVal("ill_pwr", 32'(powerLed), 32'd1);
    checkVal("ill_set", 32'(setLed), 32'd1);

    // Reset pulse in the middle of a pause blink; codes >= 58 pass through
    state = 3'd5;
    data  = 10'h0C3;
    dig[0] = 6'd60; dig[1] = 6'd2; dig[2] = 6'd63;
    repeat (6) tick();
    #2;
    rst_n = 1'b0;
    #1;
    checkVal("arst_led", 32'(led), 32'h0);
    checkVal("arst_sel", 32'(scanSel), 32'b001);
    checkVal("arst_code", 32'(scanCode), 32'd55);
    checkVal("arst_pwr", 32'(powerLed), 32'd0);
    repeat (2) tick();
    checkVal("arst_hold_sel", 32'(scanSel), 32'b001);
    rst_n = 1'b1;
    cyc   = 0;
    checkPause(1, 8, "post_rst");

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
